// File: rtl/ssd_scan_ctl_if.sv
// Bus between the datapath (packed BCD source) and the seven-segment scan controller.
// master = data source / display consumer side, slave = ssd_scan_ctl.
interface ssd_scan_ctl_if #(
    parameter int DIGITS = 4
);
    logic                        en;
    logic [4*DIGITS-1:0]         din;
    logic [DIGITS-1:0]           dp_in;
    logic [3:0]                  intossd;
    logic                        dp;
    logic [DIGITS-1:0]           lightctl;
    logic [$clog2(DIGITS)-1:0]   digit_idx;
    logic                        frame_done;

    modport master (
        output en, din, dp_in,
        input  intossd, dp, lightctl, digit_idx, frame_done
    );

    modport slave (
        input  en, din, dp_in,
        output intossd, dp, lightctl, digit_idx, frame_done
    );
endinterface

// File: rtl/ssd_scan_ctl.sv
// Multiplexed seven-segment scan controller: prescaler, slot index, frame shadow buffer, dead-time blanking.
// Optional leading-zero blanking is compiled in with `define SSD_SCAN_LZB_EN.
module ssd_scan_ctl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic          clk,
    input  logic          rst,
    ssd_scan_ctl_if.slave bus
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_V  = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] sh_d;
    logic [DIGITS-1:0]   sh_dp;
    logic                wrap_p0;

    logic                last_cnt;
    logic                last_idx;
    logic                wrap;
    logic [DIGITS-1:0]   lz_blank;
    logic [DIGITS-1:0]   lc_next;

    logic [3:0]          intossd_p1;
    logic                dp_p1;
    logic [DIGITS-1:0]   lightctl_p1;
    logic [IDX_W-1:0]    digit_idx_p1;
    logic                frame_done_p1;

    assign last_cnt = (cnt == CNT_LAST);
    assign last_idx = (idx == IDX_LAST);
    assign wrap     = bus.en && last_cnt && last_idx;

    // Stage p0: prescaler, slot index and frame shadow buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            sh_d    <= '0;
            sh_dp   <= '0;
            wrap_p0 <= 1'b0;
        end else begin
            wrap_p0 <= wrap;
            if (bus.en) begin
                if (last_cnt) begin
                    cnt <= '0;
                    idx <= last_idx ? '0 : idx + IDX_W'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (wrap) begin
                sh_d  <= bus.din;
                sh_dp <= bus.dp_in;
            end
        end
    end

`ifdef SSD_SCAN_LZB_EN
    logic upper_zero;

    // A digit is suppressed when it and every digit to its left are zero with no decimal point.
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (sh_d[4*k +: 4] != 4'd0 || sh_dp[k]) begin
                upper_zero = 1'b0;
            end
            lz_blank[k] = upper_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        lc_next = '1;
        if (bus.en && (cnt >= BLANK_V) && !lz_blank[idx]) begin
            lc_next[idx] = 1'b0;
        end
    end

    // Stage p1: registered display outputs, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (rst) begin
            intossd_p1    <= '0;
            dp_p1         <= 1'b0;
            lightctl_p1   <= '1;
            digit_idx_p1  <= '0;
            frame_done_p1 <= 1'b0;
        end else begin
            lightctl_p1   <= lc_next;
            digit_idx_p1  <= idx;
            frame_done_p1 <= wrap_p0 && bus.en;
            if (bus.en) begin
                intossd_p1 <= sh_d[4*idx +: 4];
                dp_p1      <= sh_dp[idx];
            end
        end
    end

    assign bus.intossd    = intossd_p1;
    assign bus.dp         = dp_p1;
    assign bus.lightctl   = lightctl_p1;
    assign bus.digit_idx  = digit_idx_p1;
    assign bus.frame_done = frame_done_p1;
endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Bench for ssd_scan_ctl: directed scenarios plus random traffic against a time-based reference model.
// The model counts enabled cycles since reset and derives slot/phase with division and modulo.
module tb_ssd_scan_ctl;
    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
`ifdef SSD_SCAN_LZB_EN
    localparam bit LZB_ON = 1'b1;
`else
    localparam bit LZB_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    ssd_scan_ctl_if #(.DIGITS(DIGITS)) bus ();

    ssd_scan_ctl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model state
    int unsigned m_t;
    logic [15:0] m_shd;
    logic [3:0]  m_shdp;
    bit          m_pend;
    logic [3:0]  e_int;
    logic        e_dp;
    logic [3:0]  e_lc;
    logic [1:0]  e_idx;
    logic        e_fd;

    function automatic bit lz_dark(int slot);
        return LZB_ON && slot >= 1 && (m_shd >> (4*slot)) == 16'd0 && (m_shdp >> slot) == 4'd0;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int slot;
        int c;
        bit dark;
        slot = int'((m_t / SCAN_DIV) % DIGITS);
        c    = int'(m_t % SCAN_DIV);
        if (rst) begin
            e_lc = 4'hF; e_int = 4'h0; e_dp = 1'b0; e_idx = 2'd0; e_fd = 1'b0;
            m_t = 0; m_shd = '0; m_shdp = '0; m_pend = 1'b0;
        end else begin
            dark  = !bus.en || c < BLANK_CYC || lz_dark(slot);
            e_lc  = dark ? 4'hF : ~(4'b0001 << slot);
            if (bus.en) begin
                e_int = 4'(m_shd >> (4*slot));
                e_dp  = m_shdp[slot];
            end
            e_idx  = 2'(slot);
            e_fd   = bus.en && m_pend;
            m_pend = bus.en && slot == DIGITS - 1 && c == SCAN_DIV - 1;
            if (m_pend) begin
                m_shd  = bus.din;
                m_shdp = bus.dp_in;
            end
            if (bus.en) m_t++;
        end
        @(posedge clk);
        #1;
        check("lightctl",   16'(bus.lightctl),   16'(e_lc));
        check("intossd",    16'(bus.intossd),    16'(e_int));
        check("dp",         16'(bus.dp),         16'(e_dp));
        check("digit_idx",  16'(bus.digit_idx),  16'(e_idx));
        check("frame_done", 16'(bus.frame_done), 16'(e_fd));
    endtask

    task automatic run_to(int slot, int c);
        bit hit = 1'b0;
        for (int i = 0; i < 4 * DIGITS * SCAN_DIV; i++) begin
            if (int'((m_t / SCAN_DIV) % DIGITS) == slot && int'(m_t % SCAN_DIV) == c) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        tests++;
        if (!hit) begin
            fails++;
            $error("FAIL run_to observed=not_reached expected=slot%0d_cnt%0d", slot, c);
        end
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b1; bus.din = '0; bus.dp_in = '0;
        m_t = 0; m_shd = '0; m_shdp = '0; m_pend = 1'b0;
        e_int = '0; e_dp = 1'b0; e_lc = '1; e_idx = '0; e_fd = 1'b0;

        // reset hold, then release into a scan of 4321
        repeat (3) step();
        rst = 1'b0; bus.din = 16'h4321;
        repeat (43) step();
        // mid-frame change at slot 1 only shows from the next frame
        bus.din = 16'h8765;
        repeat (64) step();

        // freeze at slot 2, cnt 5
        run_to(2, 5);
        bus.en = 1'b0;
        repeat (10) step();
        bus.en = 1'b1;
        repeat (20) step();

        // reset mid-frame at slot 3, cnt 4
        run_to(3, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();

        // leading-zero pattern, with and without a decimal point on digit 2
        bus.din = 16'h0050; bus.dp_in = 4'b0000;
        repeat (70) step();
        bus.dp_in = 4'b0100;
        repeat (70) step();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            bus.en = ($urandom_range(9) != 0);
            if ($urandom_range(7) == 0) bus.din = 16'($urandom) >> (4 * $urandom_range(3));
            if ($urandom_range(7) == 0) bus.dp_in = 4'($urandom) & 4'($urandom);
            rst = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0; bus.en = 1'b1;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
